// File: rtl/uart_baudgen_frac_pkg.sv
// Shared types and divider math for the fractional UART baud generator.
package uart_baudgen_frac_pkg;

  localparam int UART_INT_W  = 12;
  localparam int UART_FRAC_W = 4;

  typedef struct packed {
    logic [UART_INT_W-1:0]  int_part;
    logic [UART_FRAC_W-1:0] frac_part;
  } uart_div_t;

  // Fixed-point clk cycles per oversample tick, rounded to nearest, never 0.
  function automatic longint calc_div_fx(longint clk_hz, longint baud, longint osr, int frac_w);
    longint den;
    longint fx;
    den = baud * osr;
    fx  = ((clk_hz << frac_w) + den / 2) / den;
    return (fx < 1) ? 1 : fx;
  endfunction

endpackage

// File: rtl/uart_baudgen_frac_if.sv
// Config/tick bundle between the register block, the baud generator and the UART cores.
interface uart_baudgen_frac_if
  import uart_baudgen_frac_pkg::*;
#(
  parameter int INT_W  = UART_INT_W,
  parameter int FRAC_W = UART_FRAC_W
);
  logic              en;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;
  logic              cfg_load;
  logic              resync;
  logic              os_tick;
  logic              bit_tick;
  logic              mid_tick;
  logic              cfg_ack;

  modport master (
    output en, cfg_int, cfg_frac, cfg_load, resync,
    input  os_tick, bit_tick, mid_tick, cfg_ack
  );

  modport slave (
    input  en, cfg_int, cfg_frac, cfg_load, resync,
    output os_tick, bit_tick, mid_tick, cfg_ack
  );
endinterface

// File: rtl/uart_baudgen_frac_divider.sv
// Fractional-N period counter: int clocks per period, plus one extra clock
// whenever the fractional accumulator overflows.
module uart_frac_divider #(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic              acc_clr,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os
);
  logic [INT_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [INT_W-1:0]  eff_int;
  logic [FRAC_W-1:0] eff_frac;
  logic [INT_W:0]    last;
  logic [FRAC_W:0]   sum;

  // A zero divider degenerates to one tick per clock with no fraction.
  always_comb begin
    eff_int  = (div_int == '0) ? INT_W'(1) : div_int;
    eff_frac = (div_int == '0) ? '0 : div_frac;
    last     = {1'b0, eff_int} + {{INT_W{1'b0}}, carry} - (INT_W+1)'(1);
    sum      = {1'b0, acc} + {1'b0, eff_frac};
    os       = en && !clear && ({1'b0, cnt} == last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else if (!en || clear) begin
      cnt   <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else if (os) begin
      cnt <= '0;
      if (acc_clr) {carry, acc} <= '0;
      else         {carry, acc} <= sum;
    end else begin
      cnt <= cnt + INT_W'(1);
    end
  end
endmodule

// File: rtl/uart_baudgen_frac.sv
// Fractional UART baud generator: oversample, bit and mid-bit ticks with
// bit-aligned runtime reconfiguration and RX phase resync.
module uart_baudgen_frac
  import uart_baudgen_frac_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEFAULT_BAUD = 9_600,
  parameter int OSR          = 16,
  parameter int INT_W        = UART_INT_W,
  parameter int FRAC_W       = UART_FRAC_W
)(
  input logic            clk,
  input logic            rst_n,
  uart_baudgen_frac_if.slave bus
);
  localparam int     SUB_W   = $clog2(OSR);
  localparam longint DEF_FX  = calc_div_fx(CLK_HZ, DEFAULT_BAUD, OSR, FRAC_W);
  localparam longint INT_MAX = (longint'(1) << INT_W) - 1;
  localparam logic [INT_W-1:0]  DEF_INT  =
    INT_W'(((DEF_FX >> FRAC_W) > INT_MAX) ? INT_MAX : (DEF_FX >> FRAC_W));
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FX);

  uart_div_t        act, shadow;
  logic             pending;
  logic [SUB_W-1:0] sub;
  logic             os, boundary, apply;
  logic             os_r, bit_r, mid_r, ack_r;

  uart_frac_divider #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .clear    (bus.resync),
    .acc_clr  (apply),
    .div_int  (act.int_part),
    .div_frac (act.frac_part),
    .os       (os)
  );

  // New divider only takes effect on a bit edge so a frame never mixes rates.
  always_comb begin
    boundary = os && (sub == SUB_W'(OSR-1));
    apply    = pending && (boundary || !bus.en || bus.resync);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act     <= '{int_part: DEF_INT, frac_part: DEF_FRAC};
      shadow  <= '0;
      pending <= 1'b0;
      sub     <= '0;
      os_r    <= 1'b0;
      bit_r   <= 1'b0;
      mid_r   <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      os_r  <= os;
      bit_r <= boundary;
      mid_r <= os && (sub == SUB_W'(OSR/2-1));
      ack_r <= apply;

      if (!bus.en || bus.resync) sub <= '0;
      else if (os)               sub <= sub + SUB_W'(1);

      if (bus.cfg_load) shadow <= '{int_part: bus.cfg_int, frac_part: bus.cfg_frac};

      // A load landing on the apply edge wins over the older shadow value.
      if (apply) begin
        act     <= bus.cfg_load ? '{int_part: bus.cfg_int, frac_part: bus.cfg_frac} : shadow;
        pending <= 1'b0;
      end else if (bus.cfg_load) begin
        pending <= 1'b1;
      end
    end
  end

  assign bus.os_tick  = os_r;
  assign bus.bit_tick = bit_r;
  assign bus.mid_tick = mid_r;
  assign bus.cfg_ack  = ack_r;
endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Self-checking bench: random and directed stimulus against a tick-schedule model.
module tb_uart_baudgen_frac;
  localparam int OSR    = 16;
  localparam int INT_W  = 12;
  localparam int FRAC_W = 4;
  localparam int FR     = 1 << FRAC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_baudgen_frac_if #(.INT_W(INT_W), .FRAC_W(FRAC_W)) bus();

  uart_baudgen_frac #(
    .CLK_HZ(50_000_000), .DEFAULT_BAUD(9600), .OSR(OSR), .INT_W(INT_W), .FRAC_W(FRAC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: active/shadow divider, clocks left in current period, fractional phase, tick index
  int   m_int, m_frac, s_int, s_frac;
  bit   m_pend;
  int   left, phase, idx;
  logic e_os, e_bit, e_mid, e_ack;
  bit   en_s, rs_s;

  int cyc_n = 0, last_bit = 0, bit_gap = 0, os_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic int eff_i();
    return (m_int == 0) ? 1 : m_int;
  endfunction
  function automatic int eff_f();
    return (m_int == 0) ? 0 : m_frac;
  endfunction

  task automatic model_reset();
    m_int = 325; m_frac = 8; s_int = 0; s_frac = 0; m_pend = 0;
    phase = 0; idx = 0; left = eff_i();
    e_os = 0; e_bit = 0; e_mid = 0; e_ack = 0;
  endtask

  task automatic model_step();
    bit tick, app, extra;
    en_s = bus.en; rs_s = bus.resync;
    e_os = 0; e_bit = 0; e_mid = 0; tick = 0; extra = 0;
    if (en_s && !rs_s) begin
      left--;
      tick = (left == 0);
    end
    app   = m_pend && (!en_s || rs_s || (tick && idx == OSR-1));
    e_ack = app;
    if (tick) begin
      e_os  = 1;
      e_bit = (idx == OSR-1);
      e_mid = (idx == OSR/2-1);
      idx   = (idx + 1) % OSR;
      if (app) phase = 0;
      else begin
        phase = phase + eff_f();
        extra = (phase >= FR);
        phase = phase % FR;
      end
    end
    if (bus.cfg_load) begin s_int = bus.cfg_int; s_frac = bus.cfg_frac; end
    if (app) begin m_int = s_int; m_frac = s_frac; m_pend = 0; end
    else if (bus.cfg_load) m_pend = 1;
    if (!en_s || rs_s) begin left = eff_i(); phase = 0; idx = 0; end
    else if (tick) left = eff_i() + int'(extra);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("os_tick", bus.os_tick, e_os);
    chk("bit_tick", bus.bit_tick, e_bit);
    chk("mid_tick", bus.mid_tick, e_mid);
    chk("cfg_ack", bus.cfg_ack, e_ack);
    cyc_n++;
    if (!en_s || rs_s) os_cnt = 0;
    if (bus.os_tick) os_cnt++;
    if (bus.mid_tick) chk("mid_pos", os_cnt, OSR/2);
    if (bus.bit_tick) begin
      chk("bit_pos", os_cnt, OSR);
      os_cnt   = 0;
      bit_gap  = cyc_n - last_bit;
      last_bit = cyc_n;
    end
  endtask

  task automatic run_bits(input int n, input int budget);
    int seen = 0, k = 0;
    while (seen < n && k < budget) begin
      cyc(); k++;
      if (bus.bit_tick) seen++;
    end
    chk("bits_reached", seen, n);
  endtask

  task automatic wait_os_cnt(input int target, input int budget);
    int k = 0;
    while (os_cnt != target && k < budget) begin cyc(); k++; end
    chk("os_cnt_reach", os_cnt, target);
  endtask

  task automatic count_to_os(input int budget, output int k);
    k = 0;
    do begin cyc(); k++; end while (!bus.os_tick && k < budget);
  endtask

  task automatic load(input int i, input int f);
    bus.cfg_int = INT_W'(i); bus.cfg_frac = FRAC_W'(f); bus.cfg_load = 1;
    cyc();
    bus.cfg_load = 0;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_os"},  bus.os_tick,  0);
    chk({tag, "_bit"}, bus.bit_tick, 0);
    chk({tag, "_mid"}, bus.mid_tick, 0);
    chk({tag, "_ack"}, bus.cfg_ack,  0);
  endtask

  initial begin
    int k;
    logic a1, a2;
    bus.en = 0; bus.cfg_int = '0; bus.cfg_frac = '0; bus.cfg_load = 0; bus.resync = 0;
    model_reset();
    #12;
    chk_zero_outs("reset");
    @(negedge clk);
    rst_n = 1;

    // default rate: 325/326 periods, 5208 clk per steady bit
    bus.en = 1;
    last_bit = cyc_n;
    run_bits(2, 12000);
    chk("default_bit_gap", bit_gap, 5208);

    // mid-bit reconfiguration to 115200
    wait_os_cnt(5, 3000);
    load(27, 2);
    run_bits(3, 8000);
    chk("fast_bit_gap", bit_gap, 434);

    // resync mid-bit
    wait_os_cnt(5, 1000);
    bus.resync = 1; cyc(); bus.resync = 0;
    count_to_os(100, k);
    chk("resync_first_os", k, 27);
    run_bits(1, 1000);

    // load while disabled, then re-enable
    bus.en = 0; cyc(); cyc();
    bus.cfg_int = 12'd40; bus.cfg_frac = 4'd5; bus.cfg_load = 1;
    cyc(); a1 = bus.cfg_ack; bus.cfg_load = 0;
    cyc(); a2 = bus.cfg_ack;
    chk("ack_within2", a1 | a2, 1);
    cyc();
    bus.en = 1;
    count_to_os(100, k);
    chk("reenable_first_os", k, 40);

    // clamped zero divider
    bus.en = 0; cyc();
    load(0, 15);
    cyc();
    bus.en = 1;
    run_bits(3, 200);
    chk("zero_div_bit_gap", bit_gap, 16);

    // random reconfiguration, resync and enable traffic
    for (int i = 0; i < 3000; i++) begin
      bus.en       = ($urandom_range(0, 99) != 0);
      bus.cfg_load = ($urandom_range(0, 199) == 0);
      bus.cfg_int  = INT_W'($urandom_range(0, 12));
      bus.cfg_frac = FRAC_W'($urandom);
      bus.resync   = ($urandom_range(0, 149) == 0);
      cyc();
    end
    bus.cfg_load = 0; bus.resync = 0; bus.en = 1;

    // async reset mid-bit with a pending load
    wait_os_cnt(3, 500);
    load(5, 1);
    cyc();
    #2 rst_n = 0;
    #1 chk_zero_outs("async_rst");
    model_reset();
    os_cnt = 0;
    @(negedge clk); chk_zero_outs("in_rst");
    @(negedge clk);
    rst_n = 1;
    last_bit = cyc_n;
    run_bits(2, 12000);
    chk("post_rst_bit_gap", bit_gap, 5208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
